clk_div_multi: RTL and testbench

- Parametrised, multi-channel successor to the board's fixed 1 Hz divider.
- Each of NUM_CH channels derives a square-wave enable-clock (ClkOut) and a single-cycle strobe (Tick) from the 100 MHz board clock.
- Divisors are runtime-programmable through a simple write port; changes are glitch-free.
- Sits between the board clock and slow consumers (display refresh, debounce, single-step logic); outputs are registered and are meant as clock enables.

---
 rtl/clk_div_multi_pkg.sv | 17 +
 rtl/clk_div_multi_if.sv | 27 ++
 rtl/clk_div_multi_chan.sv | 51 +++++
 rtl/clk_div_multi.sv | 41 ++++
 tb/tb_clk_div_multi.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_multi_pkg.sv
// Shared constants for the multi-channel clock divider: board frequency,
// default divisor and helper divisors for common output rates.
package clk_div_pkg;

    localparam int CLK_DIV_CNT_W   = 26;
    localparam int CLK_DIV_DEFAULT = 2500000;
    localparam int BOARD_FREQ_HZ   = 100000000;

    // Divisor giving a square wave of rateHz: half-period is (divisor+1) board cycles.
    function automatic int divForRate(input int rateHz);
        return BOARD_FREQ_HZ / (2 * rateHz) - 1;
    endfunction

    localparam int CLK_DIV_1HZ  = divForRate(1);
    localparam int CLK_DIV_1KHZ = divForRate(1000);

endpackage

// File: rtl/clk_div_multi_if.sv
// Control and output bundle of clk_div_multi; the master drives enables,
// sync and divisor writes, the slave returns the divided clocks and ticks.
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();

    logic [NUM_CH-1:0] En;
    logic              Sync;
    logic              WrEn;
    logic [CH_W-1:0]   WrCh;
    logic [CNT_W-1:0]  WrData;
    logic [NUM_CH-1:0] ClkOut;
    logic [NUM_CH-1:0] Tick;

    modport master (
        output En, Sync, WrEn, WrCh, WrData,
        input  ClkOut, Tick
    );

    modport slave (
        input  En, Sync, WrEn, WrCh, WrData,
        output ClkOut, Tick
    );

endinterface

// File: rtl/clk_div_multi_chan.sv
// One divider channel: up-counter against an active divisor, with a pending
// divisor that only takes effect at a half-period boundary, disable or sync.
module clk_div_chan #(
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 2500000
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Sync,
    input  logic             PendWr,
    input  logic [CNT_W-1:0] WrData,
    output logic             ClkOut,
    output logic             Tick
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] actDiv;
    logic [CNT_W-1:0] pendDiv;

    // Act always reloads from the pre-write Pend, so a write in the same
    // cycle as a boundary is deferred to the following boundary.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count   <= '0;
            actDiv  <= CNT_W'(DEFAULT_DIV);
            pendDiv <= CNT_W'(DEFAULT_DIV);
            ClkOut  <= 1'b0;
            Tick    <= 1'b0;
        end else begin
            if (PendWr) begin
                pendDiv <= WrData;
            end
            if (!En || Sync) begin
                count  <= '0;
                ClkOut <= 1'b0;
                Tick   <= 1'b0;
                actDiv <= pendDiv;
            end else if (count == actDiv) begin
                count  <= '0;
                ClkOut <= ~ClkOut;
                Tick   <= 1'b1;
                actDiv <= pendDiv;
            end else begin
                count <= count + 1'b1;
                Tick  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator: decodes the shared
// write port and replicates one divider channel per output.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CLK_DIV_CNT_W,
    parameter int DEFAULT_DIV = CLK_DIV_DEFAULT
) (
    input  logic            Clk,
    input  logic            Rst,
    clk_div_multi_if.slave  bus
);

    logic [NUM_CH-1:0] pendWr;

    // Out-of-range channel indices match no channel and are silently dropped.
    always_comb begin
        pendWr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pendWr[i] = bus.WrEn && (32'(bus.WrCh) == i);
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChan
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) uChan (
            .Clk    (Clk),
            .Rst    (Rst),
            .En     (bus.En[ch]),
            .Sync   (bus.Sync),
            .PendWr (pendWr[ch]),
            .WrData (bus.WrData),
            .ClkOut (bus.ClkOut[ch]),
            .Tick   (bus.Tick[ch])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a countdown-to-toggle reference model
// predicts ClkOut/Tick after every clock edge; a monitor compares.
module tb_clk_div_multi;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int DEF = 3;

    typedef struct packed {
        logic [NCH-1:0] clkOut;
        logic [NCH-1:0] tick;
    } expT;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    always #5 Clk = ~Clk;

    clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(2)) bus ();

    clk_div_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    expT expQ[$];
    int  compared   = 0;
    int  mismatched = 0;

    // Reference model: level of each output and cycles left until it flips.
    int mLevel[NCH];
    int mLeft[NCH];
    int mAct[NCH];
    int mPend[NCH];
    int mTick[NCH];

    function automatic void modelReset();
        for (int c = 0; c < NCH; c++) begin
            mLevel[c] = 0;
            mTick[c]  = 0;
            mAct[c]   = DEF;
            mPend[c]  = DEF;
            mLeft[c]  = DEF + 1;
        end
    endfunction

    function automatic void modelStep(input logic [NCH-1:0] en, input logic sync,
                                      input logic wrEn, input int wrCh, input int wrData);
        for (int c = 0; c < NCH; c++) begin
            if (!en[c] || sync) begin
                mLevel[c] = 0;
                mTick[c]  = 0;
                mAct[c]   = mPend[c];
                mLeft[c]  = mAct[c] + 1;
            end else begin
                mLeft[c] = mLeft[c] - 1;
                if (mLeft[c] == 0) begin
                    mLevel[c] = 1 - mLevel[c];
                    mTick[c]  = 1;
                    mAct[c]   = mPend[c];
                    mLeft[c]  = mAct[c] + 1;
                end else begin
                    mTick[c] = 0;
                end
            end
        end
        if (wrEn && wrCh < NCH) begin
            mPend[wrCh] = wrData;
        end
    endfunction

    function automatic expT modelOut();
        expT e;
        for (int c = 0; c < NCH; c++) begin
            e.clkOut[c] = (mLevel[c] != 0);
            e.tick[c]   = (mTick[c] != 0);
        end
        return e;
    endfunction

    function automatic void checkOutput(input string name, input expT act, input expT exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: ClkOut=%b Tick=%b, required ClkOut=%b Tick=%b",
                     name, $time, act.clkOut, act.tick, exp.clkOut, exp.tick);
        end
    endfunction

    task automatic applyStimulus(input logic [NCH-1:0] en, input logic sync,
                                 input logic wrEn, input logic [1:0] wrCh,
                                 input logic [CW-1:0] wrData);
        @(negedge Clk);
        bus.En     = en;
        bus.Sync   = sync;
        bus.WrEn   = wrEn;
        bus.WrCh   = wrCh;
        bus.WrData = wrData;
        modelStep(en, sync, wrEn, int'(wrCh), int'(wrData));
        expQ.push_back(modelOut());
    endtask

    task automatic runCycles(input logic [NCH-1:0] en, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(en, 1'b0, 1'b0, 2'd0, '0);
        end
    endtask

    task automatic asyncResetPulse();
        expT got;
        @(negedge Clk);
        bus.En   = '0;
        bus.Sync = 1'b0;
        bus.WrEn = 1'b0;
        #2 Rst = 1'b0;
        #1;
        got.clkOut = bus.ClkOut;
        got.tick   = bus.Tick;
        checkOutput("async_reset", got, '0);
        modelReset();
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    // Monitor: one expected entry is pushed per driven cycle.
    initial begin
        expT e;
        expT got;
        forever begin
            @(posedge Clk);
            #1;
            if (expQ.size() > 0) begin
                e          = expQ.pop_front();
                got.clkOut = bus.ClkOut;
                got.tick   = bus.Tick;
                checkOutput("scoreboard", got, e);
            end
        end
    end

    initial begin
        expT got;
        bus.En     = '0;
        bus.Sync   = 1'b0;
        bus.WrEn   = 1'b0;
        bus.WrCh   = '0;
        bus.WrData = '0;
        modelReset();
        #12;
        got.clkOut = bus.ClkOut;
        got.tick   = bus.Tick;
        checkOutput("reset_state", got, '0);
        @(negedge Clk);
        Rst = 1'b1;

        runCycles(2'b11, 12);
        applyStimulus(2'b11, 1'b0, 1'b1, 2'd1, 8'd1);
        runCycles(2'b11, 12);
        applyStimulus(2'b11, 1'b0, 1'b1, 2'd0, 8'd0);
        runCycles(2'b11, 10);
        applyStimulus(2'b11, 1'b0, 1'b1, 2'd3, 8'd7);
        runCycles(2'b11, 10);

        applyStimulus(2'b11, 1'b0, 1'b1, 2'd0, 8'd3);
        applyStimulus(2'b11, 1'b0, 1'b1, 2'd1, 8'd3);
        runCycles(2'b11, 10);
        runCycles(2'b01, 2);
        runCycles(2'b11, 5);
        applyStimulus(2'b11, 1'b1, 1'b0, 2'd0, '0);
        runCycles(2'b11, 10);

        runCycles(2'b11, 5);
        runCycles(2'b01, 1);
        runCycles(2'b11, 10);

        applyStimulus(2'b11, 1'b0, 1'b1, 2'd0, 8'd5);
        applyStimulus(2'b11, 1'b0, 1'b1, 2'd1, 8'd1);
        runCycles(2'b11, 3);
        asyncResetPulse();
        runCycles(2'b11, 12);

        for (int i = 0; i < 400; i++) begin
            logic [NCH-1:0] en;
            for (int c = 0; c < NCH; c++) begin
                en[c] = ($urandom_range(0, 9) != 0);
            end
            applyStimulus(en, ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 5) == 0),
                          2'($urandom_range(0, 3)),
                          8'($urandom_range(0, 5)));
        end

        @(posedge Clk);
        #3;
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
